// File: rtl/main_memory_ctrl.sv
// Word-organised backing memory with a fixed-latency controller serving cache
// writebacks and refill reads; a combined request commits the write before the read.
module main_memory_ctrl #(
  parameter int unsigned DEPTH_LOG2    = 10,
  parameter int unsigned READ_LATENCY  = 4,
  parameter int unsigned WRITE_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  input  logic        wr_req,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_bytes,
  output logic        busy,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        wr_done
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  r_rd_pend, w_rd_pend_nxt;
  logic [DEPTH_LOG2-1:0] r_rd_idx, r_wr_idx;
  logic [31:0]           r_wr_data;
  logic [3:0]            r_wr_be;
  logic                  r_busy, r_rd_valid, r_wr_done;
  logic [31:0]           r_rd_data;
  logic                  w_capture_rd, w_capture_wr, w_commit, w_read_fire;
  logic [31:0]           r_mem [DEPTH];

  // Byte offset and bits above the array depth alias and are deliberately dropped.
  logic w_unused;
  assign w_unused = ^{rd_addr, wr_addr};

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rd_pend_nxt = r_rd_pend;
    w_capture_rd  = 1'b0;
    w_capture_wr  = 1'b0;
    w_commit      = 1'b0;
    w_read_fire   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (wr_req) begin
          w_capture_wr  = 1'b1;
          w_capture_rd  = rd_req;
          w_rd_pend_nxt = rd_req;
          w_cnt_nxt     = WR_LOAD;
          w_state_nxt   = S_WRITE;
        end else if (rd_req) begin
          w_capture_rd = 1'b1;
          w_cnt_nxt    = RD_LOAD;
          w_state_nxt  = S_READ;
        end
      end
      S_WRITE: begin
        if (r_cnt == '0) begin
          w_commit = 1'b1;
          if (r_rd_pend) begin
            w_rd_pend_nxt = 1'b0;
            w_cnt_nxt     = RD_LOAD;
            w_state_nxt   = S_READ;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_READ: begin
        if (r_cnt == '0) begin
          w_read_fire = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_idx   <= '0;
      r_wr_idx   <= '0;
      r_wr_data  <= '0;
      r_wr_be    <= '0;
      r_busy     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_wr_done  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rd_pend  <= w_rd_pend_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_rd_valid <= w_read_fire;
      r_wr_done  <= w_commit;
      if (w_capture_rd) r_rd_idx <= rd_addr[DEPTH_LOG2+1:2];
      if (w_capture_wr) begin
        r_wr_idx  <= wr_addr[DEPTH_LOG2+1:2];
        r_wr_data <= wr_data;
        r_wr_be   <= wr_bytes;
      end
      if (w_read_fire) r_rd_data <= r_mem[r_rd_idx];
    end
  end

  // Array has no reset; reset forces IDLE so an in-flight write never commits.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (r_wr_be[b]) r_mem[r_wr_idx][8*b +: 8] <= r_wr_data[8*b +: 8];
      end
    end
  end

  assign busy     = r_busy;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign wr_done  = r_wr_done;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench for main_memory_ctrl: directed vector table, reset corner
// sequences and random transactions against a word-array reference model.
module tb_main_memory_ctrl;

  localparam int unsigned DL = 10;
  localparam int unsigned RL = 4;
  localparam int unsigned WL = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        wr_req = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_bytes = '0;
  logic        busy, rd_valid, wr_done;
  logic [31:0] rd_data;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] model [1 << DL];
  logic [31:0] last_rd  = '0;
  bit          rd_known = 1'b1;

  typedef struct {
    bit          rq;
    bit          wq;
    logic [31:0] ra;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          drop;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  main_memory_ctrl #(
    .DEPTH_LOG2   (DL),
    .READ_LATENCY (RL),
    .WRITE_LATENCY(WL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .wr_req  (wr_req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_bytes(wr_bytes),
    .busy    (busy),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .wr_done (wr_done)
  );

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % (1 << DL);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // mode: 0 = expected read data from the model, 1 = constant cexp, 2 = unchecked data
  task automatic run_txn(input bit rq, input bit wq, input logic [31:0] ra, input logic [31:0] wa,
                         input logic [31:0] wd, input logic [3:0] be, input bit drop,
                         input int mode, input logic [31:0] cexp);
    int unsigned total;
    logic [31:0] exp;
    total = (wq ? WL : 0) + (rq ? RL : 0);
    @(negedge clk);
    check("busy_idle_before_req", 32'(busy), 32'(0));
    rd_req = rq; wr_req = wq; rd_addr = ra; wr_addr = wa; wr_data = wd; wr_bytes = be;
    @(posedge clk);
    for (int unsigned k = 0; k <= total + 2; k++) begin
      @(negedge clk);
      rd_req = 1'b0; wr_req = 1'b0;
      if (drop && k == 0) begin
        rd_req  = 1'b1;
        rd_addr = 32'h0000_0200;
      end
      if (wq && k == WL) model[widx(wa)] = merge(model[widx(wa)], wd, be);
      if (rq && k == total) begin
        if (mode == 2) rd_known = 1'b0;
        else begin
          exp      = (mode == 1) ? cexp : model[widx(ra)];
          last_rd  = exp;
          rd_known = 1'b1;
        end
      end
      check("busy", 32'(busy), 32'(k < total));
      check("wr_done", 32'(wr_done), 32'(wq && k == WL));
      check("rd_valid", 32'(rd_valid), 32'(rq && k == total));
      if (rd_known) check("rd_data", rd_data, last_rd);
    end
  endtask

  task automatic reset_mid(input bit wq, input logic [31:0] a, input logic [31:0] d,
                           input int unsigned at_k);
    @(negedge clk);
    rd_req = !wq; wr_req = wq; rd_addr = a; wr_addr = a; wr_data = d; wr_bytes = 4'hF;
    @(posedge clk);
    for (int unsigned k = 0; k <= at_k; k++) begin
      @(negedge clk);
      rd_req = 1'b0; wr_req = 1'b0;
      check("busy_before_abort", 32'(busy), 32'(1));
    end
    #2 reset = 1'b0;
    #1;
    last_rd  = '0;
    rd_known = 1'b1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_rd_valid", 32'(rd_valid), 32'(0));
    check("abort_wr_done", 32'(wr_done), 32'(0));
    check("abort_rd_data", rd_data, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_req = (i % 2 == 0); rd_req = (i % 2 == 1);
      wr_addr = 32'h0000_0044; wr_data = 32'hBAD0_BAD0; wr_bytes = 4'hF; rd_addr = 32'h44;
      check("rst_hold_busy", 32'(busy), 32'(0));
      check("rst_hold_rd_valid", 32'(rd_valid), 32'(0));
      check("rst_hold_wr_done", 32'(wr_done), 32'(0));
      check("rst_hold_rd_data", rd_data, 32'h0);
    end
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{0, 1, 32'h0, 32'h40, 32'hDEADBEEF, 4'b1111, 0, 32'h0};
    vecs[1]  = '{1, 0, 32'h40, 32'h0, 32'h0, 4'b0000, 0, 32'hDEADBEEF};
    vecs[2]  = '{0, 1, 32'h0, 32'h40, 32'h11223344, 4'b0101, 0, 32'h0};
    vecs[3]  = '{1, 0, 32'h40, 32'h0, 32'h0, 4'b0000, 0, 32'hDE22BE44};
    vecs[4]  = '{1, 1, 32'h80, 32'h80, 32'hCAFEF00D, 4'b1111, 1, 32'hCAFEF00D};
    vecs[5]  = '{1, 0, 32'h1040, 32'h0, 32'h0, 4'b0000, 0, 32'hDE22BE44};
    vecs[6]  = '{0, 1, 32'h0, 32'h44, 32'h12345678, 4'b1111, 0, 32'h0};
    vecs[7]  = '{0, 1, 32'h0, 32'h44, 32'hFFFFFFFF, 4'b0000, 0, 32'h0};
    vecs[8]  = '{1, 0, 32'h47, 32'h0, 32'h0, 4'b0000, 0, 32'h12345678};
    vecs[9]  = '{1, 1, 32'h80, 32'h100, 32'hAABBCCDD, 4'b1111, 0, 32'hCAFEF00D};
    vecs[10] = '{1, 1, 32'h2080, 32'h80, 32'h00009900, 4'b0010, 0, 32'hCAFE990D};

    // Held in reset with requests toggling: every output stays at its reset value.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd_req = (i % 2 == 0); wr_req = (i % 2 == 1);
      rd_addr = 32'h40; wr_addr = 32'h40; wr_data = 32'h5555_AAAA; wr_bytes = 4'hF;
      check("init_rst_busy", 32'(busy), 32'(0));
      check("init_rst_rd_valid", 32'(rd_valid), 32'(0));
      check("init_rst_wr_done", 32'(wr_done), 32'(0));
      check("init_rst_rd_data", rd_data, 32'h0);
    end
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
    reset = 1'b1;

    run_txn(1, 0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 2, 32'h0);

    foreach (vecs[i])
      run_txn(vecs[i].rq, vecs[i].wq, vecs[i].ra, vecs[i].wa, vecs[i].wd, vecs[i].be,
              vecs[i].drop, vecs[i].rq ? 1 : 0, vecs[i].exp);

    reset_mid(1'b0, 32'h40, 32'h0, 1);
    run_txn(1, 0, 32'h40, 32'h0, 32'h0, 4'h0, 0, 1, 32'hDE22BE44);
    reset_mid(1'b1, 32'h40, 32'h0BAD_F00D, 0);
    run_txn(1, 0, 32'h40, 32'h0, 32'h0, 4'h0, 0, 1, 32'hDE22BE44);
    run_txn(1, 0, 32'h44, 32'h0, 32'h0, 4'h0, 0, 1, 32'h12345678);

    for (int w = 0; w < 16; w++)
      run_txn(0, 1, 32'h0, 32'(w * 4), $urandom, 4'hF, 0, 0, 32'h0);

    for (int n = 0; n < 60; n++) begin
      int unsigned kind;
      logic [31:0] ra, wa;
      kind = $urandom_range(0, 2);
      ra = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) << 2) | ($urandom & 32'h3);
      wa = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) << 2) | ($urandom & 32'h3);
      run_txn(kind != 0, kind != 1, ra, wa, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3) == 0, 0, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/main_memory_ctrl.md
# main_memory_ctrl

Word-organised backing memory with a fixed-latency controller. It serves the data cache's two memory-side operations: dirty-victim writebacks and refill reads after a miss. Both requests may arrive in the same cycle. The writeback is committed first and the refill is replayed afterwards, so the cache always reads back coherent data. The block runs on the rising clock edge; the cache side samples its responses on the following falling edge.

## Interface
Parameters:
- DEPTH_LOG2, 10, log2 of the number of 32-bit words in the array.
- READ_LATENCY, 4, number of cycles from read acceptance to `rd_valid`; must be ≥1.
- WRITE_LATENCY, 2, number of cycles from write acceptance to commit and `wr_done`; must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rd_req  in  1  refill request, sampled only when idle.
- rd_addr  in  32  byte address of the refill.
- wr_req  in  1  writeback request, sampled only when idle.
- wr_addr  in  32  byte address of the writeback.
- wr_data  in  32  writeback data.
- wr_bytes  in  4  byte enables; bit k covers data[8k+7:8k].
- busy  out  1  controller is not idle; requests are ignored while this is high.
- rd_valid  out  1  one-cycle pulse; `rd_data` is valid during it.
- rd_data  out  32  refill data; holds the last returned value.
- wr_done  out  1  one-cycle pulse marking the writeback commit.

## Operation
- Storage: `mem[0:2^DEPTH_LOG2-1]` × 32.
  - Word index is `addr[DEPTH_LOG2+1:2]`.
  - `addr[1:0]` and the upper address bits are ignored, so addresses alias modulo the array depth.
- Array contents are not cleared by reset.
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - `wr_req` alone: capture the write address, data and enables; load the counter with WRITE_LATENCY-1; go to WRITE.
  - `rd_req` alone: capture the read address; load the counter with READ_LATENCY-1; go to READ.
  - Both requests together: capture both; set the pending-read flag; go to WRITE.
- WRITE: decrement the counter. When it reaches 0:
  - Write the enabled bytes into the array and pulse `wr_done`.
  - If a read is pending: clear the flag, load the counter with READ_LATENCY-1, go to READ.
  - Otherwise return to IDLE.
- READ: decrement the counter. When it reaches 0:
  - Register `rd_data` from the array and pulse `rd_valid`.
  - Return to IDLE.
- A combined request whose read and write hit the same word returns the merged post-write word.
- `wr_bytes`=0000 leaves the array unchanged; `wr_done` still pulses.
- The counter is `clog2(max(READ_LATENCY,WRITE_LATENCY))` bits wide and saturates at neither end; it is only reloaded in IDLE or on the WRITE→READ transition.
- `busy` is a registered output, equal to (state != IDLE).
- Requests that arrive while busy are dropped, not queued. The requester pulses a request for one cycle while `busy`=0 and must re-issue a dropped request.

## Timing
- Reset values: `busy`=0, `rd_valid`=0, `wr_done`=0, `rd_data`=0, state IDLE, pending flag cleared.
- Reset asserted mid-operation:
  - The operation is aborted immediately.
  - An uncommitted write is discarded.
  - No `rd_valid` or `wr_done` is generated.
- Read accepted at edge T0:
  - `busy`=1 from T0 through T0+READ_LATENCY-1.
  - `rd_valid`=1 and `busy`=0 after edge T0+READ_LATENCY.
- Write accepted at T0: commit and `wr_done` occur after edge T0+WRITE_LATENCY.
- Combined request at T0:
  - `wr_done` after edge T0+WRITE_LATENCY.
  - `rd_valid` after edge T0+WRITE_LATENCY+READ_LATENCY.
  - `busy` stays high continuously in between.
- A new request can be accepted on the edge immediately after the one where `busy` returns to 0.
- Pulse width: `rd_valid` and `wr_done` are each exactly one cycle; `rd_data` is stable until the next `rd_valid`.

## Test plan
- Reset: hold `reset`=0 with requests toggling → all outputs 0 and no array change. Release and issue a read → response arrives after READ_LATENCY cycles.
- Full-word write then read:
  - Write 0xDEADBEEF to 0x40 with `wr_bytes`=1111 at T0 → `wr_done` at T0+2.
  - Read 0x40 at T1 → `rd_valid` at T1+4 with `rd_data`=0xDEADBEEF.
- Byte enables: starting from the previous state, write 0x11223344 to 0x40 with `wr_bytes`=0101 → read returns 0xDE22BE44.
- Combined request: write 0xCAFEF00D to 0x80 and read 0x80 in the same cycle T0 → `wr_done` at T0+2, `rd_valid` at T0+6 with 0xCAFEF00D, `busy` high T0..T0+5.
- Dropped request and aliasing:
  - Issue `rd_req` 0x80 at T0+1 during the write above → no extra `rd_valid`.
  - Read 0x1040 (DEPTH_LOG2=10) → returns the 0x40 contents.
- Reset mid-read: read accepted at T0, reset pulsed at T0+2 → no `rd_valid`, `busy`=0 immediately, and the next read completes normally.
